// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the round-robin Q1.15 multiply scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_STEPS = 16;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

endpackage

// File: rtl/shift_add_mult.sv
// Sequential sign/magnitude Q1.15 multiplier: one shift-add step per cycle,
// fixed MULT_STEPS latency regardless of operand values.
module shift_add_mult
    import mult_sched_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              sat
);

    localparam int CNT_W  = $clog2(MULT_STEPS);
    localparam int PROD_W = 2 * DATA_W - 1;

    logic [CNT_W-1:0]  count;
    logic              running;
    logic              sign;
    logic [DATA_W-1:0] mplier;
    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] acc;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] mag_q;

    // |most-negative| still fits DATA_W bits as an unsigned magnitude
    assign mag_a = a[DATA_W-1] ? DATA_W'(~a + 1'b1) : a;
    assign mag_b = b[DATA_W-1] ? DATA_W'(~b + 1'b1) : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
            sign    <= 1'b0;
            mplier  <= '0;
            mcand   <= '0;
            acc     <= '0;
        end else if (start) begin
            count   <= '0;
            running <= 1'b1;
            sign    <= a[DATA_W-1] ^ b[DATA_W-1];
            mplier  <= mag_a;
            mcand   <= PROD_W'(mag_b);
            acc     <= '0;
        end else if (running) begin
            if (mplier[0])
                acc <= acc + mcand;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            count  <= count + 1'b1;
            if (count == CNT_W'(MULT_STEPS - 1))
                running <= 1'b0;
        end
    end

    // High during the final step so the owner can leave its busy state on time
    assign done = running && (count == CNT_W'(MULT_STEPS - 1));

    // Truncating >> (DATA_W-1) of the magnitude rounds toward zero
    assign mag_q = acc[PROD_W-1 -: DATA_W];
    assign sat   = ~sign & mag_q[DATA_W-1];

    always_comb begin
        if (sat)
            result = DATA_W'(Q15_MAX);
        else if (sign && mag_q[DATA_W-1])
            result = DATA_W'(Q15_MIN);
        else if (sign)
            result = DATA_W'(~mag_q + 1'b1);
        else
            result = mag_q;
    end

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin arbiter sharing one shift-add Q1.15 multiplier among NUM_REQ
// effect-stage requesters; results come back tagged with the winner index.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] op_a,
    input  logic [NUM_REQ*DATA_W-1:0] op_b,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic [IDX_W-1:0]          result_idx,
    output logic                      sat,
    output logic                      busy,
    output logic                      overrun
);

    state_t                         state;
    logic [IDX_W-1:0]               ptr;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               win;
    logic [IDX_W-1:0]               cand;
    logic                           any_req;
    logic                           start;
    logic [NUM_REQ-1:0][DATA_W-1:0] a_slot;
    logic [NUM_REQ-1:0][DATA_W-1:0] b_slot;
    logic                           m_done;
    logic [DATA_W-1:0]              m_result;
    logic                           m_sat;

    assign a_slot  = op_a;
    assign b_slot  = op_b;
    assign any_req = |req;
    assign start   = (state == IDLE) && any_req;

    // Scan from the far end back toward ptr so the nearest asserted index wins
    always_comb begin
        win  = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand])
                win = cand;
        end
    end

    shift_add_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a_slot[win]),
        .b      (b_slot[win]),
        .done   (m_done),
        .result (m_result),
        .sat    (m_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            grant      <= '0;
            done       <= '0;
            result     <= '0;
            result_idx <= '0;
            sat        <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            grant <= '0;
            done  <= '0;

            if (sample_tick && (busy || any_req))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= NUM_REQ'(1) << win;
                        idx   <= win;
                        ptr   <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_done)
                        state <= DONE;
                end
                DONE: begin
                    result     <= m_result;
                    sat        <= m_sat;
                    result_idx <= idx;
                    done       <= NUM_REQ'(1) << idx;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Randomised and directed bench for mult_scheduler against an integer-arithmetic
// reference of the Q1.15 product and a round-robin winner model.
module tb_mult_scheduler;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 16;
    localparam int IDX_W   = 2;

    localparam int          D_N = 5;
    localparam int          D_IDX [D_N] = '{0, 1, 2, 0, 1};
    localparam logic [15:0] D_A   [D_N] = '{16'h4000, 16'h8000, 16'h7FFF, 16'h0000, 16'h8000};
    localparam logic [15:0] D_B   [D_N] = '{16'h4000, 16'h8000, 16'hC000, 16'h1234, 16'h7FFF};
    localparam logic [15:0] D_R   [D_N] = '{16'h2000, 16'h7FFF, 16'hC001, 16'h0000, 16'h8001};
    localparam logic        D_S   [D_N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      sample_tick = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] op_a = '0;
    logic [NUM_REQ*DATA_W-1:0] op_b = '0;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         result;
    logic [IDX_W-1:0]          result_idx;
    logic                      sat;
    logic                      busy;
    logic                      overrun;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int model_ptr = 0;

    mult_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .grant       (grant),
        .done        (done),
        .result      (result),
        .result_idx  (result_idx),
        .sat         (sat),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signed fractional product truncated toward zero, clamped at +max
    function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int p;
        int q;
        p = int'($signed(a)) * int'($signed(b));
        q = p / 32768;
        if (q > 32767) return {1'b1, 16'h7FFF};
        return {1'b0, q[15:0]};
    endfunction

    function automatic int ref_win(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (i >= 0 && i < NUM_REQ) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic fill_ops();
        for (int s = 0; s < NUM_REQ; s++) begin
            op_a[s*DATA_W +: DATA_W] = pick_op();
            op_b[s*DATA_W +: DATA_W] = pick_op();
        end
    endtask

    // Bounded poll for the next grant (want_done=0) or done pulse; t=-1 on timeout
    task automatic wait_for(input bit want_done, output logic [NUM_REQ-1:0] vec, output int t);
        vec = '0;
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (want_done ? (|done) : (|grant)) begin
                vec = want_done ? done : grant;
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({grant, done, result, result_idx, sat, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h required 0",
                     {grant, done, result, result_idx, sat, busy, overrun});
        end
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_tick_overrun got %b required 0", overrun);
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < D_N; i++) begin
            logic [NUM_REQ-1:0] gv;
            logic [NUM_REQ-1:0] dv;
            int t0;
            int tg;
            int td;
            fill_ops();
            op_a[D_IDX[i]*DATA_W +: DATA_W] = D_A[i];
            op_b[D_IDX[i]*DATA_W +: DATA_W] = D_B[i];
            req = onehot(D_IDX[i]);
            t0 = cyc;
            wait_for(1'b0, gv, tg);
            req = '0;
            fill_ops();
            n_checks++;
            if (gv !== onehot(D_IDX[i]) || tg - t0 != 1) begin
                n_fail++;
                $display("FAIL dir%0d_grant got %b at +%0d required %b at +1", i, gv, tg - t0, onehot(D_IDX[i]));
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_busy got %b required 1", i, busy);
            end
            wait_for(1'b1, dv, td);
            n_checks++;
            if (dv !== onehot(D_IDX[i]) || td - tg != 17) begin
                n_fail++;
                $display("FAIL dir%0d_done got %b at +%0d required %b at +17", i, dv, td - tg, onehot(D_IDX[i]));
            end
            n_checks++;
            if (result !== D_R[i] || sat !== D_S[i] || int'(result_idx) != D_IDX[i] || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_result got %h sat %b idx %0d busy %b required %h sat %b idx %0d busy 0",
                         i, result, sat, result_idx, busy, D_R[i], D_S[i], D_IDX[i]);
            end
            repeat (3) @(negedge clk);
            n_checks++;
            if (result !== D_R[i] || sat !== D_S[i]) begin
                n_fail++;
                $display("FAIL dir%0d_hold got %h sat %b required %h sat %b", i, result, sat, D_R[i], D_S[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] gv;
        logic [NUM_REQ-1:0] dv;
        int tg;
        int td;
        int tprev;
        int w;
        apply_reset();
        req = '1;
        tprev = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            w = ref_win(req, model_ptr);
            wait_for(1'b0, gv, tg);
            n_checks++;
            if (gv !== onehot(w) || (k > 0 && tg - tprev != 18)) begin
                n_fail++;
                $display("FAIL rr_grant%0d got %b gap %0d required %b gap 18", k, gv, tg - tprev, onehot(w));
            end
            model_ptr = (w + 1) % NUM_REQ;
            tprev = tg;
            req = req & ~gv;
        end
        wait_for(1'b1, dv, td);
        n_checks++;
        if (dv !== onehot(NUM_REQ - 1) || int'(result_idx) != NUM_REQ - 1) begin
            n_fail++;
            $display("FAIL rr_last_done got %b idx %0d required %b idx %0d", dv, result_idx, onehot(NUM_REQ - 1), NUM_REQ - 1);
        end
        req = 3'b011;
        w = ref_win(req, model_ptr);
        wait_for(1'b0, gv, tg);
        req = '0;
        n_checks++;
        if (gv !== onehot(w)) begin
            n_fail++;
            $display("FAIL rr_wrap got %b required %b", gv, onehot(w));
        end
        model_ptr = (w + 1) % NUM_REQ;
        wait_for(1'b1, dv, td);
    endtask

    task automatic test_overrun_reset();
        logic [NUM_REQ-1:0] gv;
        logic [NUM_REQ-1:0] dv;
        int tg;
        int td;
        bit saw;
        apply_reset();
        fill_ops();
        req = 3'b001;
        wait_for(1'b0, gv, tg);
        req = '0;
        repeat (4) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set got %b required 1", overrun);
        end
        wait_for(1'b1, dv, td);
        repeat (5) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky got %b required 1", overrun);
        end
        fill_ops();
        req = 3'b010;
        wait_for(1'b0, gv, tg);
        req = '0;
        n_checks++;
        if (gv !== 3'b010) begin
            n_fail++;
            $display("FAIL pre_reset_grant got %b required 010", gv);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        n_checks++;
        if ({grant, done, result, result_idx, sat, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL midbusy_reset got %h required 0",
                     {grant, done, result, result_idx, sat, busy, overrun});
        end
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (|done) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_done got %b required 0", saw);
        end
        req = 3'b110;
        wait_for(1'b0, gv, tg);
        req = '0;
        n_checks++;
        if (gv !== onehot(ref_win(3'b110, model_ptr))) begin
            n_fail++;
            $display("FAIL ptr_after_reset got %b required %b", gv, onehot(ref_win(3'b110, model_ptr)));
        end
        model_ptr = 2;
        wait_for(1'b1, dv, td);
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            logic [NUM_REQ-1:0] r;
            logic [NUM_REQ-1:0] gv;
            logic [NUM_REQ-1:0] dv;
            logic [16:0] exp_v;
            int w;
            int tg;
            int td;
            fill_ops();
            r = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            w = ref_win(r, model_ptr);
            exp_v = ref_mul(op_a[w*DATA_W +: DATA_W], op_b[w*DATA_W +: DATA_W]);
            req = r;
            wait_for(1'b0, gv, tg);
            req = '0;
            fill_ops();
            n_checks++;
            if (gv !== onehot(w)) begin
                n_fail++;
                $display("FAIL rnd%0d_grant req %b got %b required %b", it, r, gv, onehot(w));
            end
            model_ptr = (w + 1) % NUM_REQ;
            wait_for(1'b1, dv, td);
            n_checks++;
            if (dv !== onehot(w) || td - tg != 17 || {sat, result} !== exp_v || int'(result_idx) != w) begin
                n_fail++;
                $display("FAIL rnd%0d_done got %b +%0d sat %b res %h idx %0d required %b +17 sat %b res %h idx %0d",
                         it, dv, td - tg, sat, result, result_idx, onehot(w), exp_v[16], exp_v[15:0], w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_overrun_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
